// File: rtl/fetch_pc_select.sv
// Fetch PC selection: branch/ret correction muxing, registered next-PC prediction, and a
// return-address stack plus in-order ret prediction FIFO, both built only when RET_PREDICT_EN is defined.
module fetch_pc_select #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        f_valid,
  input  logic        f_stall,
  input  logic [3:0]  f_icode,
  input  logic [63:0] f_valC,
  input  logic [63:0] f_valP,
  input  logic [3:0]  M_icode,
  input  logic        M_cnd,
  input  logic [63:0] M_valA,
  input  logic [3:0]  W_icode,
  input  logic [63:0] W_valM,
  output logic [63:0] f_pc,
  output logic [63:0] pred_pc,
  output logic        ret_predicted,
  output logic        redirect
);

  localparam logic [3:0] I_JXX  = 4'h7;
  localparam logic [3:0] I_CALL = 4'h8;
  localparam logic [3:0] I_RET  = 4'h9;

  logic        m_mispredict;
  logic        w_ret;
  logic        w_redirect;
  logic [63:0] ret_target;
  logic [63:0] pred_next;

  assign m_mispredict = (M_icode == I_JXX) && !M_cnd;
  assign w_ret        = (W_icode == I_RET);
  assign redirect     = m_mispredict || w_redirect;
  assign f_pc         = m_mispredict ? M_valA : (w_redirect ? W_valM : pred_pc);

`ifdef RET_PREDICT_EN
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [2:0] FQ_DEPTH = 3'd5;

  logic        accept;
  logic        f_is_call;
  logic        f_is_ret;

  logic [63:0] ras [RAS_DEPTH];
  logic [PW-1:0] ras_wp;
  logic [PW-1:0] ras_top;
  logic [PW:0]   ras_cnt;
  logic          ras_hit;

  logic [63:0] fq_tgt  [5];
  logic        fq_pred [5];
  logic [2:0]  fq_head;
  logic [2:0]  fq_tail;
  logic [2:0]  fq_cnt;
  logic        head_ok;
  logic        fq_deq;
  logic        fq_enq;

  function automatic logic [2:0] fq_inc(input logic [2:0] p);
    return (p == 3'd4) ? 3'd0 : p + 3'd1;
  endfunction

  assign accept    = f_valid && !f_stall;
  assign f_is_call = f_valid && (f_icode == I_CALL);
  assign f_is_ret  = f_valid && (f_icode == I_RET);

  assign ras_top       = ras_wp - PW'(1);
  assign ras_hit       = (ras_cnt != '0);
  assign ret_target    = ras_hit ? ras[ras_top] : f_valP;
  assign ret_predicted = f_is_ret && ras_hit;

  // An empty FIFO head counts as unpredicted, so a W ret with nothing queued always corrects.
  assign head_ok    = (fq_cnt != 3'd0) && fq_pred[fq_head] && (fq_tgt[fq_head] == W_valM);
  assign w_redirect = w_ret && !head_ok;

  assign fq_deq = w_ret && (fq_cnt != 3'd0);
  assign fq_enq = accept && f_is_ret && !redirect && ((fq_cnt != FQ_DEPTH) || fq_deq);

  // Stack pointer/count; a push on a full stack overwrites the oldest entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ras_wp  <= '0;
      ras_cnt <= '0;
    end else if (accept && f_is_call) begin
      ras_wp <= ras_wp + PW'(1);
      if (ras_cnt != (PW+1)'(RAS_DEPTH))
        ras_cnt <= ras_cnt + (PW+1)'(1);
    end else if (accept && f_is_ret && ras_hit) begin
      ras_wp  <= ras_top;
      ras_cnt <= ras_cnt - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (accept && f_is_call)
      ras[ras_wp] <= f_valP;
  end

  // Any redirect squashes everything younger than the W-stage ret, which empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq_head <= '0;
      fq_tail <= '0;
      fq_cnt  <= '0;
    end else if (redirect) begin
      fq_head <= '0;
      fq_tail <= '0;
      fq_cnt  <= '0;
    end else begin
      if (fq_deq)
        fq_head <= fq_inc(fq_head);
      if (fq_enq)
        fq_tail <= fq_inc(fq_tail);
      case ({fq_enq, fq_deq})
        2'b10:   fq_cnt <= fq_cnt + 3'd1;
        2'b01:   fq_cnt <= fq_cnt - 3'd1;
        default: fq_cnt <= fq_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fq_enq) begin
      fq_tgt[fq_tail]  <= ret_target;
      fq_pred[fq_tail] <= ras_hit;
    end
  end
`else
  assign ret_target    = f_valP;
  assign ret_predicted = 1'b0;
  assign w_redirect    = w_ret;
`endif

  always_comb begin
    pred_next = f_valP;
    if (f_valid) begin
      case (f_icode)
        I_JXX, I_CALL: pred_next = f_valC;
        I_RET:         pred_next = ret_target;
        default:       pred_next = f_valP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pred_pc <= RESET_PC;
    else if (!f_stall)
      pred_pc <= pred_next;
  end

endmodule

// File: tb/tb_fetch_pc_select.sv
// Scoreboard bench for fetch_pc_select; exercises the RET_PREDICT_EN build when that macro is defined.
module tb_fetch_pc_select;

  localparam logic [3:0] NOP  = 4'h1;
  localparam logic [3:0] IRMV = 4'h3;
  localparam logic [3:0] JXX  = 4'h7;
  localparam logic [3:0] CALL = 4'h8;
  localparam logic [3:0] RET  = 4'h9;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        f_valid = 1'b0, f_stall = 1'b0, M_cnd = 1'b0;
  logic [3:0]  f_icode = '0, M_icode = '0, W_icode = '0;
  logic [63:0] f_valC = '0, f_valP = '0, M_valA = '0, W_valM = '0;
  logic [63:0] f_pc, pred_pc;
  logic        ret_predicted, redirect;

  fetch_pc_select #(.RESET_PC(64'h0), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_valid(f_valid), .f_stall(f_stall), .f_icode(f_icode), .f_valC(f_valC), .f_valP(f_valP),
    .M_icode(M_icode), .M_cnd(M_cnd), .M_valA(M_valA),
    .W_icode(W_icode), .W_valM(W_valM),
    .f_pc(f_pc), .pred_pc(pred_pc), .ret_predicted(ret_predicted), .redirect(redirect)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          id;
    logic [63:0] fpc;
    logic [63:0] ppc;
    logic        rd;
    logic        rp;
  } exp_t;

  exp_t exp_q[$];
  int   neg_count = 0;
  int   step_id = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic apply_stimulus(input logic fv, input logic fs, input logic [3:0] fi,
                                input logic [63:0] fc, input logic [63:0] fp,
                                input logic [3:0] mi, input logic mc, input logic [63:0] ma,
                                input logic [3:0] wi, input logic [63:0] wm);
    @(posedge clk);
    #1;
    f_valid = fv; f_stall = fs; f_icode = fi; f_valC = fc; f_valP = fp;
    M_icode = mi; M_cnd = mc; M_valA = ma;
    W_icode = wi; W_valM = wm;
  endtask

  task automatic expect_out(input logic [63:0] fpc, input logic [63:0] ppc,
                            input logic rd, input logic rp);
    exp_t e;
    step_id++;
    e.due = neg_count + 1;
    e.id  = step_id;
    e.fpc = fpc; e.ppc = ppc; e.rd = rd; e.rp = rp;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    apply_stimulus(0, 0, 4'h0, 64'h0, 64'h0, 4'h0, 0, 64'h0, 4'h0, 64'h0);
    expect_out(64'h0, 64'h0, 0, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  function automatic void check_output(input exp_t e);
    checks += 4;
    if (f_pc !== e.fpc) begin
      errors++;
      $display("[TB] FAIL step%0d f_pc got %h want %h", e.id, f_pc, e.fpc);
    end
    if (pred_pc !== e.ppc) begin
      errors++;
      $display("[TB] FAIL step%0d pred_pc got %h want %h", e.id, pred_pc, e.ppc);
    end
    if (redirect !== e.rd) begin
      errors++;
      $display("[TB] FAIL step%0d redirect got %b want %b", e.id, redirect, e.rd);
    end
    if (ret_predicted !== e.rp) begin
      errors++;
      $display("[TB] FAIL step%0d ret_predicted got %b want %b", e.id, ret_predicted, e.rp);
    end
  endfunction

  // Monitor: every falling edge, retire the expectations that fall due on it.
  initial begin
    forever begin
      @(negedge clk);
      neg_count++;
      while (exp_q.size() > 0 && exp_q[0].due <= neg_count)
        check_output(exp_q.pop_front());
    end
  end

  initial begin
    do_reset();
    apply_stimulus(1, 0, IRMV, 64'h0, 64'hA, 0, 0, 0, 0, 0);       expect_out(64'h0, 64'h0, 0, 0);
    apply_stimulus(1, 0, JXX, 64'h40, 64'h1D, 0, 0, 0, 0, 0);      expect_out(64'hA, 64'hA, 0, 0);
    apply_stimulus(0, 0, CALL, 64'h123, 64'h41, 0, 0, 0, 0, 0);    expect_out(64'h40, 64'h40, 0, 0);
    apply_stimulus(1, 0, NOP, 64'h0, 64'h1E, JXX, 0, 64'h1D, 0, 0); expect_out(64'h1D, 64'h41, 1, 0);
    apply_stimulus(1, 1, JXX, 64'h77, 64'h55, JXX, 1, 64'h9, 0, 0); expect_out(64'h1E, 64'h1E, 0, 0);
    apply_stimulus(0, 0, NOP, 64'h0, 64'h60, 0, 0, 0, 0, 0);       expect_out(64'h1E, 64'h1E, 0, 0);
`ifdef RET_PREDICT_EN
    apply_stimulus(1, 0, CALL, 64'h100, 64'h20, 0, 0, 0, 0, 0);    expect_out(64'h60, 64'h60, 0, 0);
    apply_stimulus(1, 0, RET, 64'h0, 64'h101, 0, 0, 0, 0, 0);      expect_out(64'h100, 64'h100, 0, 1);
    apply_stimulus(1, 0, NOP, 64'h0, 64'h21, 0, 0, 0, RET, 64'h20); expect_out(64'h20, 64'h20, 0, 0);
    // Five calls into a four-entry stack, then five rets: oldest return address is lost.
    for (int k = 1; k <= 5; k++) begin
      logic [63:0] pc;
      pc = (k == 1) ? 64'h21 : 64'h1000 + 64'(k - 1);
      apply_stimulus(1, 0, CALL, 64'h1000 + 64'(k), 64'h10 * 64'(k), 0, 0, 0, 0, 0);
      expect_out(pc, pc, 0, 0);
    end
    for (int k = 1; k <= 5; k++) begin
      logic [63:0] pc;
      pc = (k == 1) ? 64'h1005 : 64'h10 * 64'(7 - k);
      apply_stimulus(1, 0, RET, 64'h0, 64'h500 + 64'(k), 0, 0, 0, 0, 0);
      expect_out(pc, pc, 0, (k < 5));
    end
    for (int i = 1; i <= 5; i++) begin
      logic [63:0] pc;
      logic [63:0] wm;
      pc = (i == 1) ? 64'h505 : 64'h600 + 64'(i - 2);
      wm = (i < 5) ? 64'h10 * 64'(6 - i) : 64'h60;
      apply_stimulus(0, 0, NOP, 64'h0, 64'h600 + 64'(i - 1), 0, 0, 0, RET, wm);
      if (i < 5) expect_out(pc, pc, 0, 0);
      else       expect_out(64'h60, 64'h603, 1, 0);
    end
    apply_stimulus(1, 0, CALL, 64'h700, 64'h70, 0, 0, 0, 0, 0);    expect_out(64'h604, 64'h604, 0, 0);
    apply_stimulus(1, 0, CALL, 64'h800, 64'h80, 0, 0, 0, 0, 0);    expect_out(64'h700, 64'h700, 0, 0);
    apply_stimulus(1, 0, RET, 64'h0, 64'h801, 0, 0, 0, 0, 0);      expect_out(64'h800, 64'h800, 0, 1);
    apply_stimulus(1, 0, RET, 64'h0, 64'h81, 0, 0, 0, 0, 0);       expect_out(64'h80, 64'h80, 0, 1);
    apply_stimulus(1, 0, RET, 64'h0, 64'h71, JXX, 0, 64'h111, RET, 64'h99);
    expect_out(64'h111, 64'h70, 1, 0);
    apply_stimulus(1, 0, CALL, 64'h900, 64'h90, 0, 0, 0, 0, 0);    expect_out(64'h71, 64'h71, 0, 0);
    apply_stimulus(1, 0, CALL, 64'hA00, 64'hB0, 0, 0, 0, 0, 0);    expect_out(64'h900, 64'h900, 0, 0);
    apply_stimulus(1, 0, RET, 64'h0, 64'hA01, 0, 0, 0, 0, 0);      expect_out(64'hA00, 64'hA00, 0, 1);
    apply_stimulus(1, 0, RET, 64'h0, 64'hB1, 0, 0, 0, RET, 64'hB0); expect_out(64'hB0, 64'hB0, 0, 1);
    apply_stimulus(0, 0, NOP, 64'h0, 64'hC0, 0, 0, 0, RET, 64'h90); expect_out(64'h90, 64'h90, 0, 0);
    apply_stimulus(1, 0, CALL, 64'hE00, 64'hD0, 0, 0, 0, 0, 0);    expect_out(64'hC0, 64'hC0, 0, 0);
    apply_stimulus(1, 0, RET, 64'h0, 64'hE01, 0, 0, 0, 0, 0);      expect_out(64'hE00, 64'hE00, 0, 1);
`else
    apply_stimulus(1, 0, CALL, 64'h100, 64'h61, 0, 0, 0, 0, 0);    expect_out(64'h60, 64'h60, 0, 0);
    apply_stimulus(1, 0, RET, 64'h0, 64'h101, 0, 0, 0, 0, 0);      expect_out(64'h100, 64'h100, 0, 0);
    apply_stimulus(1, 0, NOP, 64'h0, 64'h89, 0, 0, 0, RET, 64'h88); expect_out(64'h88, 64'h101, 1, 0);
    apply_stimulus(0, 0, NOP, 64'h0, 64'h201, JXX, 0, 64'h200, RET, 64'h300);
    expect_out(64'h200, 64'h89, 1, 0);
    apply_stimulus(0, 0, NOP, 64'h0, 64'hD00, 0, 0, 0, 0, 0);      expect_out(64'h201, 64'h201, 0, 0);
`endif
    // Reset in the middle of a program drops all queued predictions.
    do_reset();
    apply_stimulus(1, 0, RET, 64'h0, 64'h5, 0, 0, 0, RET, 64'hD0); expect_out(64'hD0, 64'h0, 1, 0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++)
      @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain pending got %0d want 0", exp_q.size());
    end
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_pc_select.md
FETCH_PC_SELECT -- requirements
Module: fetch_pc_select

Interface
REQ-001 SHALL expose parameters: RESET_PC, 64'h0, fetch address after reset; RAS_DEPTH, 4, return-address-stack entries (power of two).
REQ-002 SHALL have ports: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: f_valid  in  1  fetched instruction real, not bubble; f_stall  in  1  hold fetch; f_icode  in  4; f_valC  in  64; f_valP  in  64.
REQ-004 SHALL have ports: M_icode  in  4; M_cnd  in  1; M_valA  in  64  fall-through PC of jXX in memory stage.
REQ-005 SHALL have ports: W_icode  in  4; W_valM  in  64  return address popped by ret in writeback.
REQ-006 SHALL have ports: f_pc  out  64  fetch address this cycle; pred_pc  out  64  registered predicted PC; ret_predicted  out  1  fetched ret has stack-predicted target; redirect  out  1  f_pc is a correction, younger stages to be squashed.

Function
REQ-007 SHALL drive f_pc combinationally, priority: (a) M_icode==7 && !M_cnd -> M_valA; (b) W ret redirect (REQ-013) -> W_valM; (c) else pred_pc.
REQ-008 SHALL assert redirect in the same cycle as case (a) or (b); if both hold, (a) wins and redirect asserts once.
REQ-009 SHALL load pred_pc at rising clk when !f_stall, else hold: icode 7 (jXX) or 8 (call) -> f_valC; icode 9 (ret) -> REQ-012 target; all others -> f_valP.
REQ-010 SHALL ignore f_icode (load f_valP, no stack/FIFO change) when f_valid==0.
REQ-011 SHALL treat a fetch as accepted only when f_valid && !f_stall; stack and FIFO update only on accepted fetches.
REQ-012 Ret target: stack non-empty -> top entry, pop, ret_predicted=1; stack empty -> f_valP, ret_predicted=0.
REQ-013 W ret redirect: W_icode==9 always redirects when the FIFO head is marked unpredicted or W_valM != head target; no redirect on match; head dequeued on every W ret.
REQ-014 Accepted call SHALL push f_valP; on full stack the write pointer wraps and overwrites the oldest entry, count saturating at RAS_DEPTH.
REQ-015 Every accepted ret SHALL enqueue {predicted flag, target} into a 5-entry in-order prediction FIFO; a sixth outstanding ret cannot occur (five stages F..W).
REQ-016 On redirect, all FIFO entries younger than the one dequeued this cycle SHALL be discarded; an accepted fetch in the same cycle SHALL NOT enqueue (it is squashed).
REQ-017 Stack contents SHALL NOT be repaired on redirect; mispredictions from a corrupted stack are corrected through REQ-013.
REQ-018 W ret dequeue and accepted-ret enqueue in the same cycle without redirect SHALL both take effect, occupancy unchanged.

Reset
REQ-019 rst_n low SHALL asynchronously set pred_pc=RESET_PC, stack count and pointers 0, FIFO empty; f_pc then equals RESET_PC, ret_predicted=0, redirect=0 absent M/W correction.
REQ-020 Reset deassertion mid-program SHALL discard all in-flight prediction state; the first W ret afterwards with empty FIFO SHALL redirect.

Configuration
REQ-021 Macro RET_PREDICT_EN: defined -> stack and FIFO built, REQ-012..REQ-018 apply.
REQ-022 RET_PREDICT_EN undefined -> no stack/FIFO; fetched ret loads f_valP into pred_pc, ret_predicted tied 0, every W ret redirects to W_valM.

Verification
REQ-023 Reset: rst_n low with clk running -> f_pc=0, pred_pc=0; after release, fetch irmovq with f_valP=0xA -> pred_pc=0xA next edge.
REQ-024 Branch: fetch jXX f_valC=0x40 -> pred_pc=0x40; then M_icode=7, M_cnd=0, M_valA=0x1D -> f_pc=0x1D, redirect=1 same cycle.
REQ-025 Call/ret (macro on): call f_valP=0x20 then ret -> pred_pc=0x20, ret_predicted=1; W ret W_valM=0x20 -> redirect=0.
REQ-026 Stack overflow: 5 calls f_valP 0x10..0x50, then 5 rets -> targets 0x50,0x40,0x30,0x20 then unpredicted f_valP; fifth W ret redirects.
REQ-027 Simultaneous: M mispredict and W ret mismatch in same cycle -> f_pc=M_valA, FIFO younger entries flushed, later W ret uses next correct head.
REQ-028 Macro off: any ret -> ret_predicted=0, pred_pc=f_valP; W ret W_valM=0x88 -> f_pc=0x88, redirect=1.
